// File: rtl/seg_fade_chaser_if.sv
// rtl/seg_fade_chaser_if.sv - switch inputs and LED drive of seg_fade_chaser
interface seg_fade_chaser_if #(
  parameter int NUM_CH = 8
);
  logic [2:0]        speed;
  logic              direction;
  logic [1:0]        mode;
  logic [NUM_CH-1:0] led;

  modport master (output speed, output direction, output mode, input led);
  modport slave  (input speed, input direction, input mode, output led);
endinterface

// File: rtl/seg_fade_chaser.sv
// rtl/seg_fade_chaser.sv - multi-channel LED chaser with geometric PWM fade trails
module seg_fade_chaser #(
  parameter int NUM_CH   = 8,
  parameter int BRIGHT_W = 5,
  parameter int STEP_W   = 24,
  parameter int FADE_W   = 21,
  parameter int SEQ_LEN  = 8,
  parameter logic [SEQ_LEN*$clog2(NUM_CH)-1:0] SEQ =
    {3'd5, 3'd6, 3'd2, 3'd3, 3'd4, 3'd6, 3'd1, 3'd0},
  parameter bit  ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  seg_fade_chaser_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_CH);
  localparam int POS_W = $clog2(SEQ_LEN);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(SEQ_LEN - 1);

  localparam logic [1:0] MODE_WRAP   = 2'd0;
  localparam logic [1:0] MODE_BOUNCE = 2'd1;
  localparam logic [1:0] MODE_BLANK  = 2'd3;

  logic [2:0]          speed_q;
  logic                dir_q;
  logic [1:0]          mode_q;
  logic [STEP_W-1:0]   step_cnt_q, step_cnt_d;
  logic [FADE_W-1:0]   fade_cnt_q;
  logic [BRIGHT_W-1:0] pwm_cnt_q;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic                bdir_q, bdir_d;
  logic [BRIGHT_W-1:0] bright_q [NUM_CH];
  logic [BRIGHT_W-1:0] bright_d [NUM_CH];
  logic [NUM_CH-1:0]   lit_q, lit_d;

  logic [STEP_W-1:0]   step_limit;
  logic                step_evt;
  logic                fade_tick;
  logic [IDX_W-1:0]    head_idx;

  assign step_limit = {speed_q, {(STEP_W-3){1'b1}}};
  // >= rather than == so a speed decrease below the running count steps at once
  assign step_evt   = (step_cnt_q >= step_limit);
  assign step_cnt_d = step_evt ? '0 : step_cnt_q + 1'b1;
  assign fade_tick  = &fade_cnt_q;
  assign head_idx   = SEQ[int'(pos_q)*IDX_W +: IDX_W];

  always_comb begin
    pos_d  = pos_q;
    bdir_d = bdir_q;
    if (step_evt) begin
      case (mode_q)
        MODE_WRAP: begin
          if (dir_q) pos_d = (pos_q == POS_LAST) ? '0 : pos_q + 1'b1;
          else       pos_d = (pos_q == '0) ? POS_LAST : pos_q - 1'b1;
        end
        MODE_BOUNCE: begin
          // turn around on the end position itself so it is shown only once
          if (bdir_q) begin
            if (pos_q == POS_LAST) begin
              pos_d  = pos_q - 1'b1;
              bdir_d = 1'b0;
            end else begin
              pos_d  = pos_q + 1'b1;
            end
          end else begin
            if (pos_q == '0) begin
              pos_d  = pos_q + 1'b1;
              bdir_d = 1'b1;
            end else begin
              pos_d  = pos_q - 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      bright_d[i] = fade_tick ? (bright_q[i] >> 1) : bright_q[i];
      if (mode_q != MODE_BLANK && head_idx == IDX_W'(i)) bright_d[i] = '1;
      lit_d[i] = (bright_q[i] > pwm_cnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      speed_q    <= '0;
      dir_q      <= 1'b0;
      mode_q     <= '0;
      step_cnt_q <= '0;
      fade_cnt_q <= '0;
      pwm_cnt_q  <= '0;
      pos_q      <= '0;
      bdir_q     <= 1'b1;
      bright_q   <= '{default: '0};
      lit_q      <= '0;
    end else begin
      speed_q    <= bus.speed;
      dir_q      <= bus.direction;
      mode_q     <= bus.mode;
      step_cnt_q <= step_cnt_d;
      fade_cnt_q <= fade_cnt_q + 1'b1;
      pwm_cnt_q  <= pwm_cnt_q + 1'b1;
      pos_q      <= pos_d;
      bdir_q     <= bdir_d;
      bright_q   <= bright_d;
      lit_q      <= lit_d;
    end
  end

  assign bus.led = ACTIVE_LOW ? ~lit_q : lit_q;

endmodule

// File: tb/tb_seg_fade_chaser.sv
// tb/tb_seg_fade_chaser.sv - directed self-checking bench for seg_fade_chaser
module tb_seg_fade_chaser;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;
  int   lowc;
  int   acc;
  int   seq_ch [8] = '{0, 1, 6, 4, 3, 2, 6, 5};
  int   bounce_exp [16] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2};

  seg_fade_chaser_if #(.NUM_CH(8)) bus ();

  seg_fade_chaser #(.STEP_W(6), .FADE_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // three reset edges with junk inputs; returns on the negedge before the first live edge
  task automatic apply_reset(input logic [2:0] s, input logic d, input logic [1:0] m);
    reset         = 1'b1;
    bus.speed     = 3'd5;
    bus.direction = 1'b0;
    bus.mode      = 2'd3;
    repeat (3) @(negedge clk);
    bus.speed     = s;
    bus.direction = d;
    bus.mode      = m;
    reset         = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;

    // reset state and full-brightness duty with the head frozen on channel 0
    apply_reset(3'd0, 1'b1, 2'd2);
    check_eq("reset_led", 32'(bus.led), 32'hFF);
    @(negedge clk);
    check_eq("first_head", 32'(dut.bright_q[0]), 31);
    lowc = 0;
    for (int n = 2; n <= 33; n++) begin
      @(negedge clk);
      if (!bus.led[0]) lowc++;
    end
    check_eq("pwm_duty_31", lowc, 31);
    check_eq("others_off", 32'(bus.led[7:1]), 32'h7F);

    // wrap forward, 8-cycle steps
    apply_reset(3'd0, 1'b1, 2'd0);
    for (int n = 1; n <= 65; n++) begin
      @(negedge clk);
      if (n % 8 == 0 || n % 8 == 7) check_eq("fwd_pos", 32'(dut.pos_q), (n / 8) % 8);
      if (n % 8 == 1) check_eq("fwd_head", 32'(dut.bright_q[seq_ch[(n / 8) % 8]]), 31);
    end

    // wrap reverse
    apply_reset(3'd0, 1'b0, 2'd0);
    for (int n = 1; n <= 65; n++) begin
      @(negedge clk);
      if (n % 8 == 0 || n % 8 == 7) check_eq("rev_pos", 32'(dut.pos_q), (8 - (n / 8) % 8) % 8);
      if (n % 8 == 1) check_eq("rev_head", 32'(dut.bright_q[seq_ch[(8 - (n / 8) % 8) % 8]]), 31);
    end

    // speed 7 -> 0 while the count is above the new limit
    apply_reset(3'd7, 1'b1, 2'd0);
    repeat (39) @(negedge clk);
    check_eq("spd_cnt39", 32'(dut.step_cnt_q), 39);
    bus.speed = 3'd0;
    @(negedge clk);
    check_eq("spd_cnt40", 32'(dut.step_cnt_q), 40);
    check_eq("spd_pos_before", 32'(dut.pos_q), 0);
    @(negedge clk);
    check_eq("spd_pos_after", 32'(dut.pos_q), 1);
    check_eq("spd_cnt_clr", 32'(dut.step_cnt_q), 0);

    // fade trail of channel 0 after the head leaves it at cycle 64
    apply_reset(3'd7, 1'b1, 2'd0);
    lowc = 0;
    for (int n = 1; n <= 145; n++) begin
      @(negedge clk);
      if (n >= 97 && n <= 112 && !bus.led[0]) lowc++;
      case (n)
        63:  check_eq("fade_pos63", 32'(dut.pos_q), 0);
        64: begin
          check_eq("fade_pos64", 32'(dut.pos_q), 1);
          check_eq("head_over_fade", 32'(dut.bright_q[0]), 31);
        end
        79:  check_eq("fade_79", 32'(dut.bright_q[0]), 31);
        80:  check_eq("fade_80", 32'(dut.bright_q[0]), 15);
        95:  check_eq("fade_95", 32'(dut.bright_q[0]), 15);
        96:  check_eq("fade_96", 32'(dut.bright_q[0]), 7);
        112: begin
          check_eq("fade_112", 32'(dut.bright_q[0]), 3);
          check_eq("pwm_duty_7", lowc, 7);
        end
        128: check_eq("fade_128", 32'(dut.bright_q[0]), 1);
        144: check_eq("fade_144", 32'(dut.bright_q[0]), 0);
        default: ;
      endcase
    end

    // bounce from position 0
    apply_reset(3'd0, 1'b1, 2'd1);
    for (int n = 1; n <= 128; n++) begin
      @(negedge clk);
      if (n % 8 == 0) check_eq("bounce_pos", 32'(dut.pos_q), bounce_exp[n / 8 - 1]);
    end

    // freeze at position 2 for 100 steps
    bus.mode = 2'd2;
    for (int i = 1; i <= 800; i++) begin
      @(negedge clk);
      if (i % 100 == 0) check_eq("freeze_pos", 32'(dut.pos_q), 2);
    end
    check_eq("freeze_head", 32'(dut.bright_q[6]), 31);

    // blank: head load stops, fade ticks at 944..1008 drain channel 6
    bus.mode = 2'd3;
    repeat (79) @(negedge clk);
    check_eq("blank_1007", 32'(dut.bright_q[6]), 1);
    @(negedge clk);
    check_eq("blank_1008", 32'(dut.bright_q[6]), 0);
    @(negedge clk);
    acc = 0;
    for (int i = 0; i < 8; i++) acc = acc | 32'(dut.bright_q[i]);
    check_eq("blank_all_zero", acc, 0);
    check_eq("blank_led", 32'(bus.led), 32'hFF);
    check_eq("blank_pos", 32'(dut.pos_q), 2);

    // reset in the middle of a trail
    apply_reset(3'd0, 1'b1, 2'd0);
    repeat (20) @(negedge clk);
    check_eq("trail_pre", 32'(dut.bright_q[1]), 31);
    reset = 1'b1;
    @(negedge clk);
    acc = 0;
    for (int i = 0; i < 8; i++) acc = acc | 32'(dut.bright_q[i]);
    check_eq("mid_rst_bright", acc, 0);
    check_eq("mid_rst_led", 32'(bus.led), 32'hFF);
    check_eq("mid_rst_pos", 32'(dut.pos_q), 0);
    check_eq("mid_rst_cnt", 32'(dut.step_cnt_q), 0);
    reset = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_head", 32'(dut.bright_q[0]), 31);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
